// File: rtl/fpio_pace_ctrl.sv
// Paced byte sequencer between the fpio host FIFOs and the external pin interface.
// TX drains the host FIFO with a programmable inter-byte gap; RX pushes bytes and tracks overruns.
module fpio_pace_ctrl #(
  parameter int unsigned FIFO_BITS  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  divisor,
  input  logic [FIFO_BITS:0]    irq_thresh,
  input  logic                  irq_clr,
  input  logic [FIFO_BITS:0]    tx_count,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_pop,
  output logic [DATA_WIDTH-1:0] ext_data_o,
  output logic                  ext_valid_o,
  input  logic                  ext_ready_i,
  input  logic                  rx_valid_i,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic [FIFO_BITS:0]    rx_free,
  input  logic [FIFO_BITS:0]    rx_count,
  output logic                  rx_push,
  output logic [DATA_WIDTH-1:0] rx_wdata,
  output logic [15:0]           ovr_cnt,
  output logic                  busy,
  output logic                  irq
);

  localparam int unsigned OVR_W = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_POP     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  gap_q, gap_d;
  logic [DATA_WIDTH-1:0] ext_data_q, ext_data_d;
  logic                  tx_pop_q, tx_pop_d;
  logic                  ext_valid_q, ext_valid_d;
  logic                  busy_q, busy_d;
  logic                  sticky_q, sticky_d;
  logic [OVR_W-1:0]      ovr_cnt_q, ovr_cnt_d;
  logic                  irq_q, irq_d;
  logic                  ovr_event;

  // TX sequencing; strobes are registered from the next state so they line up with it
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    ext_data_d = ext_data_q;
    case (state_q)
      S_IDLE:    if (en && (tx_count != '0)) state_d = S_POP;
      S_POP:     state_d = S_WAIT;
      S_WAIT: begin
        ext_data_d = tx_data;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (ext_ready_i) begin
          if (divisor != '0) begin
            gap_d   = divisor - DIV_WIDTH'(1);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - DIV_WIDTH'(1);
      end
      default:   state_d = S_IDLE;
    endcase
    tx_pop_d    = (state_d == S_POP);
    ext_valid_d = (state_d == S_PRESENT);
    busy_d      = (state_d != S_IDLE);
  end

  // RX overrun tracking and interrupt level; a new overrun wins over irq_clr
  always_comb begin
    ovr_event = rx_valid_i && (rx_free == '0);
    sticky_d  = sticky_q;
    if (irq_clr)   sticky_d = 1'b0;
    if (ovr_event) sticky_d = 1'b1;
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_event && (ovr_cnt_q != {OVR_W{1'b1}})) ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
    irq_d = sticky_d || ((irq_thresh != '0) && (rx_count >= irq_thresh));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      ext_data_q  <= '0;
      tx_pop_q    <= 1'b0;
      ext_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sticky_q    <= 1'b0;
      ovr_cnt_q   <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      ext_data_q  <= ext_data_d;
      tx_pop_q    <= tx_pop_d;
      ext_valid_q <= ext_valid_d;
      busy_q      <= busy_d;
      sticky_q    <= sticky_d;
      ovr_cnt_q   <= ovr_cnt_d;
      irq_q       <= irq_d;
    end
  end

  assign tx_pop      = tx_pop_q;
  assign ext_data_o  = ext_data_q;
  assign ext_valid_o = ext_valid_q;
  assign busy        = busy_q;
  assign ovr_cnt     = ovr_cnt_q;
  assign irq         = irq_q;
  assign rx_push     = rx_valid_i && (rx_free != '0);
  assign rx_wdata    = rx_data_i;

endmodule

// File: tb/tb_fpio_pace_ctrl.sv
// Directed bench for fpio_pace_ctrl: RX/irq vector table plus TX pacing, stall, en and reset sequences.
module tb_fpio_pace_ctrl;
  logic        clk, rst, en, irq_clr, ext_ready_i, rx_valid_i;
  logic [31:0] divisor;
  logic [8:0]  irq_thresh, tx_count, rx_free, rx_count;
  logic [7:0]  tx_data, rx_data_i, ext_data_o, rx_wdata;
  logic        tx_pop, ext_valid_o, rx_push, busy, irq;
  logic [15:0] ovr_cnt;

  fpio_pace_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .divisor(divisor), .irq_thresh(irq_thresh),
    .irq_clr(irq_clr), .tx_count(tx_count), .tx_data(tx_data), .tx_pop(tx_pop),
    .ext_data_o(ext_data_o), .ext_valid_o(ext_valid_o), .ext_ready_i(ext_ready_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_free(rx_free), .rx_count(rx_count),
    .rx_push(rx_push), .rx_wdata(rx_wdata), .ovr_cnt(ovr_cnt), .busy(busy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_count = 0;
  int underflow = 0;
  logic [7:0] txq[$];
  logic [7:0] hs_data[$];
  int         hs_cyc[$];

  // TX FIFO model and handshake monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (ext_valid_o && ext_ready_i) begin
      hs_data.push_back(ext_data_o);
      hs_cyc.push_back(cyc);
    end
    if (tx_pop) begin
      pop_count++;
      if (txq.size() == 0) underflow++;
      else tx_data = txq.pop_front();
    end
    tx_count = 9'(txq.size());
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    hs_data.delete();
    hs_cyc.delete();
    pop_count = 0;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k;
    k = 0;
    while (hs_data.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("hs_timeout", 32'(hs_data.size()), 32'(n));
  endtask

  typedef struct {
    logic       vld;
    logic [8:0] free;
    logic [8:0] cnt;
    logic [8:0] th;
    logic       clr;
    logic [7:0] data;
    logic       e_push;
    logic [15:0] e_ovr;
    logic       e_irq;
  } rx_vec_t;

  rx_vec_t vt[12];

  initial begin
    logic ok;
    int k;
    vt[0]  = '{1'b1, 9'd3, 9'd0, 9'd0, 1'b0, 8'h11, 1'b1, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 9'd0, 9'd0, 9'd0, 1'b0, 8'h22, 1'b0, 16'd1, 1'b1};
    vt[2]  = '{1'b1, 9'd0, 9'd0, 9'd0, 1'b0, 8'h33, 1'b0, 16'd2, 1'b1};
    vt[3]  = '{1'b1, 9'd0, 9'd0, 9'd0, 1'b0, 8'h44, 1'b0, 16'd3, 1'b1};
    vt[4]  = '{1'b0, 9'd0, 9'd0, 9'd0, 1'b1, 8'h55, 1'b0, 16'd3, 1'b0};
    vt[5]  = '{1'b0, 9'd5, 9'd3, 9'd4, 1'b0, 8'h66, 1'b0, 16'd3, 1'b0};
    vt[6]  = '{1'b1, 9'd5, 9'd4, 9'd4, 1'b0, 8'h77, 1'b1, 16'd3, 1'b1};
    vt[7]  = '{1'b0, 9'd5, 9'd4, 9'd0, 1'b0, 8'h88, 1'b0, 16'd3, 1'b0};
    vt[8]  = '{1'b1, 9'd0, 9'd0, 9'd0, 1'b1, 8'h99, 1'b0, 16'd4, 1'b1};
    vt[9]  = '{1'b0, 9'd0, 9'd0, 9'd0, 1'b1, 8'hAA, 1'b0, 16'd4, 1'b0};
    vt[10] = '{1'b0, 9'd8, 9'd5, 9'd4, 1'b0, 8'hBB, 1'b0, 16'd4, 1'b1};
    vt[11] = '{1'b0, 9'd8, 9'd3, 9'd4, 1'b0, 8'hCC, 1'b0, 16'd4, 1'b0};

    rst = 1'b1; en = 1'b0; divisor = 32'd0; irq_thresh = '0; irq_clr = 1'b0;
    ext_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0; rx_free = 9'd8; rx_count = '0;
    tx_count = '0; tx_data = '0;
    repeat (3) step();
    chk("rst_tx_pop", 32'(tx_pop), 0);
    chk("rst_valid", 32'(ext_valid_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ovr", 32'(ovr_cnt), 0);
    chk("rst_data", 32'(ext_data_o), 0);
    rst = 1'b0;
    step();

    // RX path, overrun sticky and irq vectors
    for (int i = 0; i < 12; i++) begin
      rx_valid_i = vt[i].vld; rx_free = vt[i].free; rx_count = vt[i].cnt;
      irq_thresh = vt[i].th; irq_clr = vt[i].clr; rx_data_i = vt[i].data;
      #1;
      chk($sformatf("v%0d_push", i), 32'(rx_push), 32'(vt[i].e_push));
      chk($sformatf("v%0d_wdata", i), 32'(rx_wdata), 32'(vt[i].data));
      step();
      chk($sformatf("v%0d_ovr", i), 32'(ovr_cnt), 32'(vt[i].e_ovr));
      chk($sformatf("v%0d_irq", i), 32'(irq), 32'(vt[i].e_irq));
    end
    rx_valid_i = 1'b0; irq_clr = 1'b0; irq_thresh = '0; rx_count = '0; rx_free = 9'd8;
    step();

    // back-to-back bytes with divisor 0
    clear_logs();
    divisor = 32'd0; ext_ready_i = 1'b1;
    txq.push_back(8'hA5); txq.push_back(8'h5A); txq.push_back(8'h3C);
    en = 1'b1;
    wait_hs(3, 40);
    if (hs_data.size() == 3) begin
      chk("a_d0", 32'(hs_data[0]), 32'hA5);
      chk("a_d1", 32'(hs_data[1]), 32'h5A);
      chk("a_d2", 32'(hs_data[2]), 32'h3C);
      chk("a_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 4);
      chk("a_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 4);
    end
    step(); step();
    chk("a_pops", 32'(pop_count), 3);
    chk("a_busy", 32'(busy), 0);

    // divisor 5 -> 9-cycle byte period
    clear_logs();
    divisor = 32'd5;
    txq.push_back(8'h01); txq.push_back(8'h02);
    wait_hs(2, 60);
    if (hs_data.size() == 2) begin
      chk("b_d1", 32'(hs_data[1]), 32'h02);
      chk("b_gap", 32'(hs_cyc[1] - hs_cyc[0]), 9);
    end
    divisor = 32'd0;
    repeat (8) step();
    chk("b_pops", 32'(pop_count), 2);
    chk("b_busy", 32'(busy), 0);

    // stalled PRESENT: data stable, single pop
    clear_logs();
    ext_ready_i = 1'b0;
    txq.push_back(8'h77);
    k = 0;
    while (!ext_valid_o && k < 20) begin step(); k++; end
    chk("c_valid", 32'(ext_valid_o), 1);
    ok = 1'b1;
    repeat (10) begin
      step();
      if (!(ext_valid_o && ext_data_o == 8'h77)) ok = 1'b0;
    end
    chk("c_stable", 32'(ok), 1);
    ext_ready_i = 1'b1;
    repeat (3) step();
    chk("c_pops", 32'(pop_count), 1);
    chk("c_hs", 32'(hs_data.size()), 1);
    chk("c_busy", 32'(busy), 0);

    // en dropped in WAIT: first byte finishes, second waits for en
    clear_logs();
    txq.push_back(8'hC1); txq.push_back(8'hC2);
    k = 0;
    while (pop_count < 1 && k < 20) begin step(); k++; end
    chk("d_first_pop", 32'(pop_count), 1);
    en = 1'b0;
    repeat (20) step();
    chk("d_hs_hold", 32'(hs_data.size()), 1);
    chk("d_pop_hold", 32'(pop_count), 1);
    chk("d_txcount", 32'(tx_count), 1);
    en = 1'b1;
    wait_hs(2, 20);
    chk("d_pops", 32'(pop_count), 2);
    if (hs_data.size() == 2) chk("d_d1", 32'(hs_data[1]), 32'hC2);
    repeat (3) step();

    // reset while presenting with irq high
    clear_logs();
    ext_ready_i = 1'b0; irq_thresh = 9'd1; rx_count = 9'd1;
    txq.push_back(8'h99);
    k = 0;
    while (!ext_valid_o && k < 20) begin step(); k++; end
    chk("e_valid", 32'(ext_valid_o), 1);
    chk("e_irq", 32'(irq), 1);
    rst = 1'b1;
    step();
    chk("e_rst_valid", 32'(ext_valid_o), 0);
    chk("e_rst_irq", 32'(irq), 0);
    chk("e_rst_busy", 32'(busy), 0);
    chk("e_rst_ovr", 32'(ovr_cnt), 0);
    irq_thresh = '0; rx_count = '0; ext_ready_i = 1'b1;
    rst = 1'b0;
    repeat (3) step();
    chk("e_after_pops", 32'(pop_count), 1);
    chk("e_after_busy", 32'(busy), 0);

    // overrun counter saturation
    rx_valid_i = 1'b1; rx_free = '0;
    repeat (65538) step();
    chk("sat_ovr", 32'(ovr_cnt), 32'hFFFF);
    chk("sat_irq", 32'(irq), 1);
    rx_valid_i = 1'b0;
    step();

    chk("no_underflow", 32'(underflow), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
